// File: rtl/shift_deser.sv
// Serial-in / parallel-out deserializer: assembles W-bit words MSB- or LSB-first from a
// qualified bit stream and holds each finished word in a one-entry valid/ready output register.
module shift_deser #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sin,
  input  logic         sin_valid,
  input  logic         sframe,
  input  logic         dir,
  input  logic         q_ready,
  input  logic         ovf_clr,
  output logic [W-1:0] q,
  output logic         q_valid,
  output logic         ovf,
  output logic         frame_err,
  output logic         busy
);

  localparam int unsigned CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [W-1:0]  sreg;
  logic [CW-1:0] cnt;
  logic          dir_l;

  logic          start_c;
  logic          restart_c;
  logic          dir_eff_c;
  logic [W-1:0]  base_c;
  logic [W-1:0]  shifted_c;
  logic          complete_c;
  logic          pop_c;
  logic [CW-1:0] cnt_nxt_c;

  // Bit-0 detection, shift-direction selection and word-completion decode.
  always_comb begin
    start_c    = 1'b0;
    restart_c  = 1'b0;
    dir_eff_c  = dir_l;
    base_c     = sreg;
    shifted_c  = sreg;
    complete_c = 1'b0;
    cnt_nxt_c  = cnt;
    pop_c      = q_valid & q_ready;

    start_c   = sin_valid & ((cnt == '0) | sframe);
    restart_c = sin_valid & sframe & (cnt != '0);
    if (start_c) begin
      dir_eff_c = dir;
      base_c    = '0;
    end
    shifted_c = dir_eff_c ? {sin, base_c[W-1:1]} : {base_c[W-2:0], sin};

    if (sin_valid) begin
      if (start_c) begin
        cnt_nxt_c = CW'(1);
      end else if (cnt == LAST) begin
        cnt_nxt_c  = '0;
        complete_c = 1'b1;
      end else begin
        cnt_nxt_c = cnt + CW'(1);
      end
    end
  end

  // Shift register, bit counter and latched direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg  <= '0;
      cnt   <= '0;
      dir_l <= 1'b0;
    end else if (sin_valid) begin
      sreg <= shifted_c;
      cnt  <= cnt_nxt_c;
      if (start_c) begin
        dir_l <= dir;
      end
    end
  end

  // One-entry output register; a pop and a completion on the same edge refill without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q         <= '0;
      q_valid   <= 1'b0;
      ovf       <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= restart_c;
      if (complete_c && (!q_valid || pop_c)) begin
        q       <= shifted_c;
        q_valid <= 1'b1;
      end else if (pop_c) begin
        q_valid <= 1'b0;
      end
      if (complete_c && q_valid && !pop_c) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: tb/tb_shift_deser.sv
// Bench for shift_deser (W=4): table of words plus hand sequences for overflow, framing,
// simultaneous pop/complete and mid-word reset; popped words are checked against a queue.
module tb_shift_deser;

  logic       clk;
  logic       rst_n;
  logic       sin;
  logic       sin_valid;
  logic       sframe;
  logic       dir;
  logic       q_ready;
  logic       ovf_clr;
  logic [3:0] q;
  logic       q_valid;
  logic       ovf;
  logic       frame_err;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_q[$];

  shift_deser #(.W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .sin_valid (sin_valid),
    .sframe    (sframe),
    .dir       (dir),
    .q_ready   (q_ready),
    .ovf_clr   (ovf_clr),
    .q         (q),
    .q_valid   (q_valid),
    .ovf       (ovf),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       d;
    logic [3:0] bits;   // bits[3] is sent first
    int         gap;
    logic [3:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard side: every accepted word must match the oldest expected entry.
  always @(posedge clk) begin
    if (rst_n && q_valid && q_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got %0h expected none", q);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (q !== e) begin
          n_fail++;
          $display("FAIL pop_word: got %0h expected %0h at %0t", q, e, $time);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic d, input logic f);
    sin       = b;
    dir       = d;
    sframe    = f;
    sin_valid = 1'b1;
    tick();
    sin_valid = 1'b0;
    sframe    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Sends four bits; dir is inverted after bit 0 to show it is ignored mid-word.
  task automatic send_word(input logic [3:0] bits, input logic d, input int gap, input logic push,
                           input logic [3:0] exp);
    for (int i = 3; i >= 0; i--) begin
      if (i == 0 && push) exp_q.push_back(exp);
      send_bit(bits[i], (i == 3) ? d : ~d, 1'b0);
      if (i != 0) idle(gap);
    end
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{d: 1'b0, bits: 4'b1011, gap: 0, exp: 4'b1011};
    tbl[1] = '{d: 1'b1, bits: 4'b1011, gap: 2, exp: 4'b1101};
    tbl[2] = '{d: 1'b0, bits: 4'b0110, gap: 1, exp: 4'b0110};
    tbl[3] = '{d: 1'b1, bits: 4'b0001, gap: 0, exp: 4'b1000};
    tbl[4] = '{d: 1'b1, bits: 4'b1100, gap: 0, exp: 4'b0011};
    tbl[5] = '{d: 1'b0, bits: 4'b1111, gap: 3, exp: 4'b1111};

    rst_n = 1'b0; sin = 1'b0; sin_valid = 1'b0; sframe = 1'b0; dir = 1'b0;
    q_ready = 1'b0; ovf_clr = 1'b0;
    idle(2);
    check("rst_q", 32'(q), 0);
    check("rst_q_valid", 32'(q_valid), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    idle(1);

    // Table: one word each, consumer always ready
    q_ready = 1'b1;
    foreach (tbl[k]) begin
      for (int i = 3; i >= 1; i--) begin
        send_bit(tbl[k].bits[i], (i == 3) ? tbl[k].d : ~tbl[k].d, 1'b0);
        check("tbl_busy_mid", 32'(busy), 1);
        check("tbl_no_valid_mid", 32'(q_valid), 0);
        idle(tbl[k].gap);
      end
      exp_q.push_back(tbl[k].exp);
      send_bit(tbl[k].bits[0], ~tbl[k].d, 1'b0);
      check("tbl_valid", 32'(q_valid), 1);
      check("tbl_q", 32'(q), 32'(tbl[k].exp));
      check("tbl_busy_done", 32'(busy), 0);
      idle(1);
      check("tbl_popped", 32'(q_valid), 0);
      check("tbl_q_retained", 32'(q), 32'(tbl[k].exp));
    end

    // Overflow: second and third words dropped; set beats clear
    q_ready = 1'b0;
    send_word(4'hA, 1'b0, 0, 1'b1, 4'hA);
    check("ovf_first_clear", 32'(ovf), 0);
    send_word(4'h5, 1'b0, 0, 1'b0, 4'h0);
    check("ovf_set", 32'(ovf), 1);
    check("ovf_q_held", 32'(q), 32'hA);
    check("ovf_valid_held", 32'(q_valid), 1);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(ovf), 0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    ovf_clr = 1'b1;
    send_bit(1'b1, 1'b0, 1'b0);
    ovf_clr = 1'b0;
    check("ovf_set_beats_clr", 32'(ovf), 1);
    check("ovf_q_held2", 32'(q), 32'hA);
    ovf_clr = 1'b1;
    q_ready = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    check("ovf_pop_valid", 32'(q_valid), 0);
    check("ovf_clr2", 32'(ovf), 0);

    // Framing error: 2 bits, then sframe restarts the word
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b1);
    check("ferr_pulse", 32'(frame_err), 1);
    check("ferr_busy", 32'(busy), 1);
    send_bit(1'b1, 1'b0, 1'b0);
    check("ferr_one_cycle", 32'(frame_err), 0);
    send_bit(1'b0, 1'b0, 1'b0);
    exp_q.push_back(4'b1100);
    send_bit(1'b0, 1'b0, 1'b0);
    check("ferr_q", 32'(q), 32'hC);
    check("ferr_valid", 32'(q_valid), 1);
    check("ferr_no_ovf", 32'(ovf), 0);
    idle(1);

    // sframe on the would-be 4th bit: no completion, new word starts
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b1);
    check("ferr4_no_valid", 32'(q_valid), 0);
    check("ferr4_pulse", 32'(frame_err), 1);
    check("ferr4_busy", 32'(busy), 1);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    exp_q.push_back(4'b0110);
    send_bit(1'b0, 1'b0, 1'b0);
    check("ferr4_q", 32'(q), 32'h6);
    idle(1);

    // Pop and completion on the same edge
    q_ready = 1'b0;
    send_word(4'b0011, 1'b0, 0, 1'b1, 4'b0011);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    q_ready = 1'b1;
    exp_q.push_back(4'b1001);
    send_bit(1'b1, 1'b0, 1'b0);
    check("same_edge_valid", 32'(q_valid), 1);
    check("same_edge_q", 32'(q), 32'h9);
    check("same_edge_no_ovf", 32'(ovf), 0);
    idle(1);
    check("same_edge_drained", 32'(q_valid), 0);

    // Reset mid-word with a held word
    q_ready = 1'b0;
    send_word(4'b0111, 1'b0, 0, 1'b1, 4'b0111);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("arst_q", 32'(q), 0);
    check("arst_valid", 32'(q_valid), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_ovf", 32'(ovf), 0);
    tick();
    rst_n = 1'b1;
    idle(1);
    q_ready = 1'b1;
    send_word(4'b1000, 1'b1, 0, 1'b1, 4'b0001);
    check("post_rst_q", 32'(q), 32'h1);
    check("post_rst_valid", 32'(q_valid), 1);
    idle(2);
    check("queue_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
